icblbc_cand_scan: RTL and testbench

Parametrised candidate scanner for the ICBLBC code search. Given a start codeword, it sweeps every codeword of length `n` bits, computes the Hamming distance to the start word in a pipelined unit, and streams qualifying codewords into two external single-port RAMs:
- the next-candidate list (distance ≥ `min_hd`);
- the isolation-candidate list (distance ≥ `min_iso`).

It replaces the fixed 8-bit, unpipelined candidate loop inside `find_iso_from_start`, and feeds the downstream isolation search.

---
 rtl/icblbc_pkg.sv | 22 ++
 rtl/icblbc_cand_scan_if.sv | 37 +++
 rtl/icblbc_hd_pipe.sv | 42 ++++
 rtl/icblbc_cand_scan.sv | 192 +++++++++++++++++++
 tb/tb_icblbc_cand_scan.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/icblbc_pkg.sv
// Shared types and constants for the ICBLBC candidate scanner.
package icblbc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PIPE_DEPTH = 3;
  // The drain must cover every code still in flight after the last issue.
  localparam int DRAIN_LEN  = PIPE_DEPTH;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + {4'd0, v[i]};
    return s;
  endfunction

endpackage

// File: rtl/icblbc_cand_scan_if.sv
// Control, status and RAM write-port bundle of the candidate scanner.
interface icblbc_cand_scan_if #(
  parameter int WIDTH  = 8,
  parameter int DIST_W = $clog2(WIDTH + 1),
  parameter int CNT_W  = WIDTH + 1
);
  localparam int N_W = $clog2(WIDTH + 1);

  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  start_code;
  logic [N_W-1:0]    n;
  logic [DIST_W-1:0] min_hd;
  logic [DIST_W-1:0] min_iso;
  logic              busy;
  logic              done;
  logic              cand_we;
  logic [WIDTH-1:0]  cand_addr;
  logic [WIDTH-1:0]  cand_data;
  logic              iso_we;
  logic [WIDTH-1:0]  iso_addr;
  logic [WIDTH-1:0]  iso_data;
  logic [CNT_W-1:0]  cand_count;
  logic [CNT_W-1:0]  iso_count;

  modport master (
    output start, abort, start_code, n, min_hd, min_iso,
    input  busy, done, cand_we, cand_addr, cand_data,
           iso_we, iso_addr, iso_data, cand_count, iso_count
  );

  modport slave (
    input  start, abort, start_code, n, min_hd, min_iso,
    output busy, done, cand_we, cand_addr, cand_data,
           iso_we, iso_addr, iso_data, cand_count, iso_count
  );
endinterface

// File: rtl/icblbc_hd_pipe.sv
// Two-stage registered XOR-and-popcount with valid/code sideband.
module icblbc_hd_pipe
  import icblbc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIST_W = $clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_code,
  input  logic [WIDTH-1:0]  ref_code,
  input  logic [WIDTH-1:0]  mask,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_code,
  output logic [DIST_W-1:0] out_dist
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_code;
  logic [WIDTH-1:0] s1_diff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_code   <= '0;
      s1_diff   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_dist  <= '0;
    end else begin
      s1_valid  <= in_valid & ~flush;
      s1_code   <= in_code;
      s1_diff   <= (in_code ^ ref_code) & mask;
      out_valid <= s1_valid & ~flush;
      out_code  <= s1_code;
      out_dist  <= DIST_W'(popcount16(16'(s1_diff)));
    end
  end

endmodule

// File: rtl/icblbc_cand_scan.sv
// Candidate scanner: sweeps 0..2^n-1, streams codes far enough from start_code
// into the candidate RAM and (with ICBLBC_ISO_LIST_EN) the isolation RAM.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing one code per cycle
// DRAIN | letting the distance pipeline empty
// DONE  | one-cycle completion pulse
module icblbc_cand_scan
  import icblbc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIST_W = $clog2(WIDTH + 1),
  parameter int CNT_W  = WIDTH + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  icblbc_cand_scan_if.slave bus
);

  localparam int N_W = $clog2(WIDTH + 1);

  state_t            state, state_nx;
  logic [WIDTH-1:0]  code, start_q, mask_q, mask_new;
  logic [DIST_W-1:0] min_hd_q;
  logic [1:0]        drain_cnt;
  logic [N_W-1:0]    n_cl;
  logic              accept, last_code, issue, flush, busy_o, done_o;

  logic              p_valid;
  logic [WIDTH-1:0]  p_code;
  logic [DIST_W-1:0] p_dist;

  logic              cand_we_q;
  logic [WIDTH-1:0]  cand_addr_q, cand_data_q;
  logic [CNT_W-1:0]  cand_count_q;
  logic              cand_hit;

  assign n_cl      = (bus.n > N_W'(WIDTH)) ? N_W'(WIDTH) : bus.n;
  assign accept    = (state == ST_IDLE) && bus.start;
  assign last_code = (code == mask_q);

  always_comb begin
    mask_new = '0;
    for (int i = 0; i < WIDTH; i++) mask_new[i] = (i < int'(n_cl));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_SCAN;
      ST_SCAN:  if (bus.abort) state_nx = ST_IDLE;
                else if (last_code) state_nx = ST_DRAIN;
      ST_DRAIN: if (bus.abort) state_nx = ST_IDLE;
                else if (drain_cnt == 2'd0) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    issue  = 1'b0;
    flush  = 1'b0;
    case (state)
      ST_SCAN:  begin busy_o = 1'b1; issue = 1'b1; flush = bus.abort; end
      ST_DRAIN: begin busy_o = 1'b1; flush = bus.abort; end
      ST_DONE:  done_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      code      <= '0;
      start_q   <= '0;
      mask_q    <= '0;
      min_hd_q  <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        code     <= '0;
        start_q  <= bus.start_code;
        mask_q   <= mask_new;
        min_hd_q <= bus.min_hd;
      end else if (state == ST_SCAN && !last_code) begin
        code <= code + WIDTH'(1);
      end
      // Down-counter reloaded throughout SCAN, so it is full on DRAIN entry.
      if (state == ST_SCAN)
        drain_cnt <= 2'(DRAIN_LEN - 1);
      else if (state == ST_DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 2'd1;
    end
  end

  icblbc_hd_pipe #(.WIDTH(WIDTH), .DIST_W(DIST_W)) u_hd_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (issue),
    .in_code  (code),
    .ref_code (start_q),
    .mask     (mask_q),
    .out_valid(p_valid),
    .out_code (p_code),
    .out_dist (p_dist)
  );

  assign cand_hit = p_valid && (p_dist >= min_hd_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cand_we_q    <= 1'b0;
      cand_addr_q  <= '0;
      cand_data_q  <= '0;
      cand_count_q <= '0;
    end else if (accept) begin
      cand_we_q    <= 1'b0;
      cand_addr_q  <= '0;
      cand_count_q <= '0;
    end else if (flush) begin
      cand_we_q <= 1'b0;
    end else begin
      cand_we_q <= cand_hit;
      if (cand_hit) begin
        cand_addr_q  <= cand_count_q[WIDTH-1:0];
        cand_data_q  <= p_code;
        cand_count_q <= cand_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.cand_we    = cand_we_q;
  assign bus.cand_addr  = cand_addr_q;
  assign bus.cand_data  = cand_data_q;
  assign bus.cand_count = cand_count_q;

`ifdef ICBLBC_ISO_LIST_EN
  logic [DIST_W-1:0] min_iso_q;
  logic              iso_we_q, iso_hit;
  logic [WIDTH-1:0]  iso_addr_q, iso_data_q;
  logic [CNT_W-1:0]  iso_count_q;

  assign iso_hit = p_valid && (p_dist >= min_iso_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_iso_q   <= '0;
      iso_we_q    <= 1'b0;
      iso_addr_q  <= '0;
      iso_data_q  <= '0;
      iso_count_q <= '0;
    end else if (accept) begin
      min_iso_q   <= bus.min_iso;
      iso_we_q    <= 1'b0;
      iso_addr_q  <= '0;
      iso_count_q <= '0;
    end else if (flush) begin
      iso_we_q <= 1'b0;
    end else begin
      iso_we_q <= iso_hit;
      if (iso_hit) begin
        iso_addr_q  <= iso_count_q[WIDTH-1:0];
        iso_data_q  <= p_code;
        iso_count_q <= iso_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.iso_we    = iso_we_q;
  assign bus.iso_addr  = iso_addr_q;
  assign bus.iso_data  = iso_data_q;
  assign bus.iso_count = iso_count_q;
`else
  logic unused_iso;
  assign unused_iso    = ^bus.min_iso;
  assign bus.iso_we    = 1'b0;
  assign bus.iso_addr  = '0;
  assign bus.iso_data  = '0;
  assign bus.iso_count = '0;
`endif

endmodule

// File: tb/tb_icblbc_cand_scan.sv
// Directed bench for icblbc_cand_scan (WIDTH=8); isolation-list expectations
// follow ICBLBC_ISO_LIST_EN.
module tb_icblbc_cand_scan;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0 = 0;

  logic [7:0] cand_mem [256];
  logic [7:0] iso_mem  [256];
  int cand_wr_n, iso_wr_n, done_n;
  int first_cand_rel, last_cand_rel, done_rel;
  logic busy_at_done;

  icblbc_cand_scan_if #(.WIDTH(8)) bus ();
  icblbc_cand_scan #(.WIDTH(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.cand_we) begin
      cand_mem[bus.cand_addr] = bus.cand_data;
      cand_wr_n++;
      if (first_cand_rel < 0) first_cand_rel = cyc - t0;
      last_cand_rel = cyc - t0;
    end
    if (bus.iso_we) begin
      iso_mem[bus.iso_addr] = bus.iso_data;
      iso_wr_n++;
    end
    if (bus.done) done_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 256; i++) begin cand_mem[i] = 8'hEE; iso_mem[i] = 8'hEE; end
    cand_wr_n = 0; iso_wr_n = 0; done_n = 0;
    first_cand_rel = -1; last_cand_rel = -1; done_rel = -1;
  endtask

  task automatic drive_start(input logic [7:0] sc, input logic [3:0] nn,
                             input logic [3:0] hd, input logic [3:0] iso);
    clear_logs();
    @(negedge clock);
    bus.start_code = sc; bus.n = nn; bus.min_hd = hd; bus.min_iso = iso;
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] sc, input logic [3:0] nn, input logic [3:0] hd,
                          input logic [3:0] iso, input int budget);
    drive_start(sc, nn, hd, iso);
    check("busy_cycle1", 32'(bus.busy), 1);
    for (int k = 0; k < budget; k++) begin
      if (bus.done) begin
        done_rel = cyc - t0;
        busy_at_done = bus.busy;
        break;
      end
      @(negedge clock);
    end
    if (done_rel < 0) check("done_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic check_iso(input string tag, input int cnt, input logic [7:0] first_val);
`ifdef ICBLBC_ISO_LIST_EN
    check({tag, "_iso_count"}, 32'(bus.iso_count), 32'(cnt));
    check({tag, "_iso_wr"}, 32'(iso_wr_n), 32'(cnt));
    if (cnt > 0) check({tag, "_iso0"}, 32'(iso_mem[0]), 32'(first_val));
`else
    check({tag, "_iso_count"}, 32'(bus.iso_count), 0);
    check({tag, "_iso_wr"}, 32'(iso_wr_n), 0);
    if (cnt < 0) check({tag, "_iso0"}, 32'(iso_mem[0]), 32'(first_val));
`endif
  endtask

  task automatic scenario1(input string tag);
    run_scan(8'h00, 4'd3, 4'd2, 4'd3, 40);
    check({tag, "_done_cyc"}, 32'(done_rel), 12);
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
    check({tag, "_cand_count"}, 32'(bus.cand_count), 4);
    check({tag, "_cand_wr"}, 32'(cand_wr_n), 4);
    check({tag, "_first_wr_cyc"}, 32'(first_cand_rel), 7);
    check({tag, "_cand0"}, 32'(cand_mem[0]), 3);
    check({tag, "_cand1"}, 32'(cand_mem[1]), 5);
    check({tag, "_cand2"}, 32'(cand_mem[2]), 6);
    check({tag, "_cand3"}, 32'(cand_mem[3]), 7);
    check_iso(tag, 1, 8'd7);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.start_code = '0;
    bus.n = '0; bus.min_hd = '0; bus.min_iso = '0;
    clear_logs();
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_cand_count", 32'(bus.cand_count), 0);
    check("rst_cand_we", 32'(bus.cand_we), 0);
    reset_n = 1'b1;
    @(negedge clock);

    scenario1("s1");

    // start_code=0x0F, n=4: every code qualifies for min_hd=0; only 0 is at distance 4.
    run_scan(8'h0F, 4'd4, 4'd0, 4'd4, 60);
    check("s2_done_cyc", 32'(done_rel), 20);
    check("s2_cand_count", 32'(bus.cand_count), 16);
    for (int i = 0; i < 16; i++) check("s2_cand_entry", 32'(cand_mem[i]), 32'(i));
    check_iso("s2", 1, 8'd0);

    run_scan(8'h00, 4'd0, 4'd0, 4'd0, 20);
    check("s3_done_cyc", 32'(done_rel), 5);
    check("s3_wr_cyc", 32'(first_cand_rel), 4);
    check("s3_cand_wr", 32'(cand_wr_n), 1);
    check("s3_cand0", 32'(cand_mem[0]), 0);
    check_iso("s3", 1, 8'd0);

    run_scan(8'h00, 4'd3, 4'd4, 4'd7, 40);
    check("s4_done_cyc", 32'(done_rel), 12);
    check("s4_cand_count", 32'(bus.cand_count), 0);
    check("s4_cand_wr", 32'(cand_wr_n), 0);
    check_iso("s4", 0, 8'd0);

    // n=12 clamps to 8; only 0x5A is at distance 8 from 0xA5.
    run_scan(8'hA5, 4'd12, 4'd8, 4'd8, 320);
    check("s5_done_cyc", 32'(done_rel), 260);
    check("s5_cand_count", 32'(bus.cand_count), 1);
    check("s5_cand0", 32'(cand_mem[0]), 32'h5A);
    check_iso("s5", 1, 8'h5A);

    // Abort: codes 1..96 written in cycles 5..100, nothing afterwards.
    drive_start(8'h00, 4'd8, 4'd1, 4'd8);
    for (int k = 2; k <= 101; k++) begin
      @(negedge clock);
      case (k)
        50: begin bus.start = 1'b1; bus.start_code = 8'h55; bus.min_hd = 4'd0; end
        51: bus.start = 1'b0;
        100: bus.abort = 1'b1;
        101: bus.abort = 1'b0;
        default: ;
      endcase
    end
    check("s6_busy_after_abort", 32'(bus.busy), 0);
    repeat (300) @(negedge clock);
    check("s6_done_n", 32'(done_n), 0);
    check("s6_cand_wr", 32'(cand_wr_n), 96);
    check("s6_last_wr_cyc", 32'(last_cand_rel), 100);
    check("s6_cand_count", 32'(bus.cand_count), 96);
    check("s6_cand0", 32'(cand_mem[0]), 1);
    check("s6_cand95", 32'(cand_mem[95]), 96);
    check_iso("s6", 0, 8'd0);

    // Reset mid-scan at cycle 20: 17 writes (codes 0..16) have appeared by then.
    drive_start(8'h00, 4'd8, 4'd0, 4'd0);
    repeat (19) @(negedge clock);
    check("s7_count_pre_rst", 32'(bus.cand_count), 17);
    reset_n = 1'b0;
    #1;
    check("s7_rst_busy", 32'(bus.busy), 0);
    check("s7_rst_cand_we", 32'(bus.cand_we), 0);
    check("s7_rst_cand_addr", 32'(bus.cand_addr), 0);
    check("s7_rst_cand_data", 32'(bus.cand_data), 0);
    check("s7_rst_cand_count", 32'(bus.cand_count), 0);
    check("s7_rst_iso_count", 32'(bus.iso_count), 0);
    check("s7_rst_iso_we", 32'(bus.iso_we), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    scenario1("s8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
